ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

EX-stage multiply/divide unit with architectural HI/LO registers, consuming the instruction and operands held in the ID/EX pipeline register. It executes MULT/MULTU/DIV/DIVU iteratively in the background and serves MFHI/MFLO/MTHI/MTLO. When the pipeline must wait for it, it asserts a stall back toward the IF/ID and ID/EX registers.

## Interface
- No parameters. Fixed 32-bit datapath, 32 iterations per operation.
- One clock; reset is asynchronous and active-low.
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_EX  input  32  instruction currently in EX; only opcode [31:26] and funct [5:0] are decoded.
- regFileDataOne_EX  input  32  rs operand (dividend, multiplicand, MTHI/MTLO source).
- regFileDataTwo_EX  input  32  rt operand (divisor, multiplier).
- hiLoData_EX  output  32  HI for MFHI, LO for MFLO, else 0; combinational.
- hiLoSel_EX  output  1  high when instr_EX is MFHI or MFLO; selects hiLoData_EX into the EX result mux.
- mdStall  output  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- mdBusy  output  1  an iterative operation is in progress.

## Operation
- Decode applies only when opcode = 0. Funct encodings:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- States:
  - IDLE: default after reset.
  - BUSY: counter 0..31, shifting accumulator plus operand registers.
- Start: in IDLE with MULT/MULTU/DIV/DIVU in EX, latch operands at the edge and go to BUSY with count = 0. The pipeline is not stalled, so the instruction leaves EX.
- Signed ops (MULT, DIV) iterate on magnitudes and latch the result signs at start.
- MULT/MULTU: unsigned shift-add over 32 iterations, giving a 64-bit product. Signed case negates the 64-bit result if the signs differ. HI = [63:32], LO = [31:0].
- DIV/DIVU: restoring division over 32 iterations. LO = quotient, HI = remainder. Signed case: quotient sign = xor of operand signs; remainder sign = dividend sign.
- Divide by zero, signed or unsigned: no iteration. Single cycle in which HI = rs and LO = 0xFFFFFFFF.
- 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- BUSY to IDLE: at count = 31, write HI/LO and return to IDLE.
- mdStall = mdBusy AND instr_EX is any of the eight md functs. Other instructions proceed during BUSY.
- MTHI/MTLO: write rs into HI/LO at the edge where the instruction is in EX and mdStall = 0.
- MFHI/MFLO when not stalled: hiLoData_EX reflects current HI/LO.
- A stalled instruction is re-evaluated every cycle. It starts or executes in the first cycle after BUSY exits, and never starts twice.
- Reset (any time, including mid-BUSY): state IDLE, count 0, HI = LO = 0, operand/accumulator registers 0. The operation in flight is discarded.

## Timing
- Start edge = T. mdBusy is high for cycles T+1 .. T+32.
- HI/LO are valid from cycle T+33.
- An MFLO immediately following MULT reaches EX at T+1 and stalls through T+32. It reads the result in cycle T+33.
- Divide by zero: mdBusy is high for one cycle (T+1). The result is valid at T+2.
- Reset values of outputs: hiLoData_EX = 0, hiLoSel_EX per decode of instr_EX (0 for a zero instruction), mdStall = 0, mdBusy = 0.
- No combinational path from mdStall back to any input.

## Structure
- Shared package mips_pkg holds:
  - funct constants (FUNCT_MFHI .. FUNCT_DIVU, OPCODE_RTYPE)
  - md state enum (MD_IDLE, MD_BUSY)
  - sign pre-/post-processing functions
- One sub-module is natural: md_iter_core, holding the 32-step shift-add/restoring datapath and counter with start/done handshake. The parent keeps decode, HI/LO and stall.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, then MFHI, then MFLO -> stall 32 cycles; HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT −3 × 7 -> after 32 cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 5 / 0 -> mdBusy high for 1 cycle; HI = 5, LO = 0xFFFFFFFF.
- MULT followed by five independent ALU ops, then MFLO -> no stall on the ALU ops; MFLO stalls 27 cycles; back-to-back MULT stalls until the first completes.
- rst low at BUSY count 10 -> mdBusy = 0 and HI = LO = 0 immediately; an MTHI 0x1234 after release -> MFHI returns 0x1234.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode constants, multiply/divide state encoding and sign helpers.
// Operands are reduced to magnitudes before iterating; results get their sign back afterwards.
package mips_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Multiply: neg_lo flips the whole 64-bit product. Divide: neg_lo flips the
    // quotient (LO) and neg_hi flips the remainder (HI) independently.
    function automatic logic [63:0] md_post(input logic [63:0] res, input logic is_div,
                                            input logic neg_lo, input logic neg_hi);
        logic [63:0] r;
        r = res;
        if (!is_div) begin
            if (neg_lo) r = ~res + 64'd1;
        end else begin
            if (neg_lo) r[31:0]  = ~res[31:0] + 32'd1;
            if (neg_hi) r[63:32] = ~res[63:32] + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// 32-step unsigned shift-add multiplier / restoring divider; start in IDLE, done pulses on the last BUSY cycle.
// Latency 32 cycles (1 for divide-by-zero); a start while BUSY is ignored, the caller must hold off.
module md_iter_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_is_div,
    input  logic        i_div_zero,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_res
);

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic        r_div_zero;

    logic [32:0] w_sum;
    logic [31:0] w_diff;
    logic        w_ge;
    logic [63:0] w_acc_step;
    logic        w_last;

    // r_acc holds {HI,LO} for multiply and {remainder,quotient} for divide.
    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_ge       = (r_acc[63:31] >= {1'b0, r_opnd});
        w_diff     = r_acc[62:31] - r_opnd;
        w_acc_step = {w_sum, r_acc[31:1]};
        if (r_is_div) begin
            w_acc_step = w_ge ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
        end
        w_last = r_div_zero || (r_cnt == 5'd31);
        o_res  = r_div_zero ? r_acc : w_acc_step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= MD_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start) w_state_nxt = MD_BUSY;
            end
            MD_BUSY: begin
                o_busy = 1'b1;
                if (w_last) begin
                    o_done      = 1'b1;
                    w_state_nxt = MD_IDLE;
                end
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 5'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (r_state == MD_IDLE) begin
            if (i_start) begin
                r_cnt      <= 5'd0;
                r_is_div   <= i_is_div;
                r_div_zero <= i_div_zero;
                if (i_div_zero) begin
                    r_acc  <= {i_a, 32'hFFFF_FFFF};
                    r_opnd <= 32'd0;
                end else if (i_is_div) begin
                    r_acc  <= {32'd0, i_a};
                    r_opnd <= i_b;
                end else begin
                    r_acc  <= {32'd0, i_b};
                    r_opnd <= i_a;
                end
            end
        end else if (!r_div_zero) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/DIV with HI/LO: decodes the EX instruction, launches the iterative core, serves MF/MT HI/LO.
// Ops run 32 cycles in the background; mdStall holds the pipe only when a md instruction meets a busy unit.
module ex_muldiv_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_EX,
    input  logic [31:0] regFileDataOne_EX,
    input  logic [31:0] regFileDataTwo_EX,
    output logic [31:0] hiLoData_EX,
    output logic        hiLoSel_EX,
    output logic        mdStall,
    output logic        mdBusy
);

    logic        w_rtype;
    logic [5:0]  w_funct;
    logic        w_is_mfhi, w_is_mthi, w_is_mflo, w_is_mtlo;
    logic        w_is_mul, w_is_div, w_is_muldiv, w_is_md;
    logic        w_signed, w_div_zero, w_start;
    logic        w_neg_lo, w_neg_hi;
    logic [31:0] w_a, w_b;
    logic        w_core_busy, w_core_done;
    logic [63:0] w_core_res, w_post;
    logic        w_unused_instr;

    logic [31:0] r_hi, r_lo;
    logic        r_neg_lo, r_neg_hi, r_is_div;

    assign w_unused_instr = ^instr_EX[25:6];

    always_comb begin
        w_rtype     = (instr_EX[31:26] == OPCODE_RTYPE);
        w_funct     = instr_EX[5:0];
        w_is_mfhi   = w_rtype && (w_funct == FUNCT_MFHI);
        w_is_mthi   = w_rtype && (w_funct == FUNCT_MTHI);
        w_is_mflo   = w_rtype && (w_funct == FUNCT_MFLO);
        w_is_mtlo   = w_rtype && (w_funct == FUNCT_MTLO);
        w_is_mul    = w_rtype && ((w_funct == FUNCT_MULT) || (w_funct == FUNCT_MULTU));
        w_is_div    = w_rtype && ((w_funct == FUNCT_DIV)  || (w_funct == FUNCT_DIVU));
        w_signed    = w_rtype && ((w_funct == FUNCT_MULT) || (w_funct == FUNCT_DIV));
        w_is_muldiv = w_is_mul || w_is_div;
        w_is_md     = w_is_muldiv || w_is_mfhi || w_is_mthi || w_is_mflo || w_is_mtlo;
        w_div_zero  = w_is_div && (regFileDataTwo_EX == 32'd0);
        // Divide-by-zero passes rs through untouched so it lands in HI unsigned-as-is.
        w_a         = w_div_zero ? regFileDataOne_EX : md_mag(regFileDataOne_EX, w_signed);
        w_b         = md_mag(regFileDataTwo_EX, w_signed);
        w_neg_lo    = !w_div_zero && w_signed && (regFileDataOne_EX[31] ^ regFileDataTwo_EX[31]);
        w_neg_hi    = !w_div_zero && w_signed && w_is_div && regFileDataOne_EX[31];
        mdBusy      = w_core_busy;
        mdStall     = w_core_busy && w_is_md;
        w_start     = w_is_muldiv && !w_core_busy;
        hiLoSel_EX  = w_is_mfhi || w_is_mflo;
        hiLoData_EX = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : 32'd0);
        w_post      = md_post(w_core_res, r_is_div, r_neg_lo, r_neg_hi);
    end

    md_iter_core u_core (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_is_div   (w_is_div),
        .i_div_zero (w_div_zero),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_busy     (w_core_busy),
        .o_done     (w_core_done),
        .o_res      (w_core_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_is_div <= 1'b0;
        end else if (w_start) begin
            r_neg_lo <= w_neg_lo;
            r_neg_hi <= w_neg_hi;
            r_is_div <= w_is_div;
        end
    end

    // MT* cannot collide with done: while busy any md instruction is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_core_done) begin
            r_hi <= w_post[63:32];
            r_lo <= w_post[31:0];
        end else if (!mdStall) begin
            if (w_is_mthi) r_hi <= regFileDataOne_EX;
            if (w_is_mtlo) r_lo <= regFileDataOne_EX;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboarded bench: MF reads push expected HI/LO; a forked monitor checks each unstalled MF read.
module tb_ex_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_EX, regFileDataOne_EX, regFileDataTwo_EX;
    logic [31:0] hiLoData_EX;
    logic        hiLoSel_EX, mdStall, mdBusy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk               (clk),
        .rst               (rst),
        .instr_EX          (instr_EX),
        .regFileDataOne_EX (regFileDataOne_EX),
        .regFileDataTwo_EX (regFileDataTwo_EX),
        .hiLoData_EX       (hiLoData_EX),
        .hiLoSel_EX        (hiLoSel_EX),
        .mdStall           (mdStall),
        .mdBusy            (mdBusy)
    );

    function automatic logic [31:0] rinst(input logic [5:0] f);
        return {OPCODE_RTYPE, 20'd0, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && hiLoSel_EX === 1'b1 && mdStall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got 0x%08h, expected no read", hiLoData_EX);
                end else begin
                    check("hilo_read", hiLoData_EX, exp_q.pop_front());
                end
            end
        end
    endtask

    // Present one instruction in EX and hold it while stalled, like the ID/EX register would.
    task automatic issue(input string name, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall);
        int stalls;
        @(posedge clk);
        #1;
        instr_EX          = i;
        regFileDataOne_EX = a;
        regFileDataTwo_EX = b;
        stalls            = 0;
        forever begin
            @(negedge clk);
            if (!mdStall) break;
            stalls++;
            if (stalls > 100) break;
        end
        check({name, "_stall"}, stalls, exp_stall);
    endtask

    task automatic mf(input string name, input logic hi, input logic [31:0] exp, input int exp_stall);
        exp_q.push_back(exp);
        issue(name, rinst(hi ? FUNCT_MFHI : FUNCT_MFLO), 32'd0, 32'd0, exp_stall);
    endtask

    initial begin
        rst               = 1'b0;
        instr_EX          = 32'd0;
        regFileDataOne_EX = 32'd0;
        regFileDataTwo_EX = 32'd0;
        fork
            monitor();
        join_none
        #1;
        check("rst_busy",  mdBusy,      32'd0);
        check("rst_stall", mdStall,     32'd0);
        check("rst_sel",   hiLoSel_EX,  32'd0);
        check("rst_data",  hiLoData_EX, 32'd0);
        instr_EX = rinst(FUNCT_MFLO);
        #1;
        check("rst_sel_mflo", hiLoSel_EX, 32'd1);
        instr_EX = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        issue("multu", rinst(FUNCT_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        mf("multu_hi", 1'b1, 32'hFFFF_FFFE, 32);
        mf("multu_lo", 1'b0, 32'h0000_0001, 0);

        issue("mult", rinst(FUNCT_MULT), 32'hFFFF_FFFD, 32'd7, 0);
        mf("mult_lo", 1'b0, 32'hFFFF_FFEB, 32);
        mf("mult_hi", 1'b1, 32'hFFFF_FFFF, 0);

        issue("div", rinst(FUNCT_DIV), 32'hFFFF_FFF9, 32'd2, 0);
        mf("div_lo", 1'b0, 32'hFFFF_FFFD, 32);
        mf("div_hi", 1'b1, 32'hFFFF_FFFF, 0);

        issue("divu", rinst(FUNCT_DIVU), 32'd100, 32'd7, 0);
        mf("divu_lo", 1'b0, 32'd14, 32);
        mf("divu_hi", 1'b1, 32'd2, 0);

        issue("divu0", rinst(FUNCT_DIVU), 32'd5, 32'd0, 0);
        mf("divu0_hi", 1'b1, 32'd5, 1);
        check("divu0_busy_after", mdBusy, 32'd0);
        mf("divu0_lo", 1'b0, 32'hFFFF_FFFF, 0);

        issue("div_ovf", rinst(FUNCT_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 0);
        mf("div_ovf_lo", 1'b0, 32'h8000_0000, 32);
        mf("div_ovf_hi", 1'b1, 32'h0000_0000, 0);

        issue("mult_bg", rinst(FUNCT_MULT), 32'd6, 32'd7, 0);
        issue("alu_add0", rinst(6'h20), 32'd1, 32'd2, 0);
        issue("alu_addi", {6'h08, 20'd0, FUNCT_MULT}, 32'd1, 32'd2, 0);
        issue("alu_add1", rinst(6'h20), 32'd3, 32'd4, 0);
        issue("alu_or",   rinst(6'h25), 32'd3, 32'd4, 0);
        issue("alu_sub",  rinst(6'h22), 32'd3, 32'd4, 0);
        mf("mult_bg_lo", 1'b0, 32'd42, 27);
        mf("mult_bg_hi", 1'b1, 32'd0, 0);

        issue("mult_b2b_a", rinst(FUNCT_MULT), 32'd3, 32'd4, 0);
        issue("mult_b2b_b", rinst(FUNCT_MULTU), 32'd5, 32'd6, 32);
        mf("b2b_lo", 1'b0, 32'd30, 32);
        mf("b2b_hi", 1'b1, 32'd0, 0);

        issue("mtlo", rinst(FUNCT_MTLO), 32'h55, 32'd0, 0);
        mf("mtlo_rd", 1'b0, 32'h55, 0);

        issue("div0_s", rinst(FUNCT_DIV), 32'hFFFF_FFFB, 32'd0, 0);
        mf("div0_s_hi", 1'b1, 32'hFFFF_FFFB, 1);
        mf("div0_s_lo", 1'b0, 32'hFFFF_FFFF, 0);

        // Abort a multiply at count 10; HI/LO hold nonzero values going in.
        issue("mult_abort", rinst(FUNCT_MULT), 32'd9, 32'd9, 0);
        @(posedge clk);
        #1;
        instr_EX = 32'd0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_pre", mdBusy, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_busy", mdBusy, 32'd0);
        check("abort_stall", mdStall, 32'd0);
        instr_EX = rinst(FUNCT_MFHI);
        #1;
        check("abort_hi", hiLoData_EX, 32'd0);
        instr_EX = rinst(FUNCT_MFLO);
        #1;
        check("abort_lo", hiLoData_EX, 32'd0);
        instr_EX = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        issue("mthi", rinst(FUNCT_MTHI), 32'h1234, 32'd0, 0);
        mf("mthi_rd", 1'b1, 32'h1234, 0);
        mf("post_rst_lo", 1'b0, 32'd0, 0);

        @(posedge clk);
        #1;
        instr_EX = 32'd0;
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
